// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single full-subtractor cell and a borrow register are reused for WIDTH cycles.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed-overflow output (ovf).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               r_bout;
    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_br_next;

    // Operand bits always come from position 0 as the shift registers move right.
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == LAST_BIT);

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_SHIFT;
            S_SHIFT: if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then process one bit per edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_bout <= w_br_next;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_sign_a;
    logic r_sign_b;
    logic r_ovf;

    assign ovf = r_ovf;

    // Signed overflow: operands of differing sign and a result whose sign differs from a.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_sign_a != r_sign_b) && (w_d != r_sign_a);
        end
    end
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor; computes diff = a - b, LSB first, one bit per clock.
- It is the inverse-operation counterpart to the datapath's bit-level full-adder arithmetic.
- Captures two WIDTH-bit operands on a start handshake and runs a single full-subtractor cell plus a borrow register for WIDTH cycles.
- Presents the difference and borrow-out with a one-cycle done pulse.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- start  input  1  request; accepted only in IDLE.
- a  input  WIDTH  minuend; sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  difference a - b modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0.
  - Internal operand shift registers, borrow register and bit counter cleared.
  - Reset takes effect mid-operation too: the calculation in progress is abandoned and no done pulse is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start = 1 at an edge: capture a and b, clear borrow to 0, clear counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each edge processes bit i (i = 0..WIDTH-1, LSB first):
    - d_i = a_i ^ b_i ^ br.
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i is shifted into diff from the MSB side, so after WIDTH shifts diff[i] = d_i.
  - Counter increments each edge. The edge processing bit WIDTH-1 moves to DONE and loads bout = br_next.
  - Counter width is $clog2(WIDTH)+1 bits; it never wraps within one operation.
- DONE: done = 1 for exactly one cycle, then unconditional return to IDLE.
- Output timing: busy = 1 exactly while state == SHIFT; done = 1 exactly while state == DONE.
- Latency: if start is accepted at edge 0, busy is high after edges 0..WIDTH-1 (WIDTH cycles). done is high in the cycle after edge WIDTH. Total start-to-done: WIDTH+1 edges.
- diff and bout are intermediate (not valid) during SHIFT. They are stable from the DONE cycle and hold their value through IDLE until the next accepted start.
- start is ignored in SHIFT and DONE; a request there is neither queued nor remembered.
- start held continuously: a new operation begins on the first IDLE edge after DONE, i.e. back-to-back throughput is one result every WIDTH+2 cycles.
- Operand changes after the accepting edge have no effect.
- Boundary results:
  - a == b gives diff = 0, bout = 0.
  - a = 0, b = 1 gives diff = all-ones, bout = 1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0.
  - ovf is loaded on the same edge as bout: ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), i.e. signed two's-complement overflow.
  - Uses captured operand sign bits; held with diff.
- Not defined: port ovf is absent; no sign-bit capture logic; all other behaviour identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start one cycle: busy high 8 cycles, then done pulse in cycle 9 after accept; diff=0x1E, bout=0.
- a=0x10, b=0x20: diff=0xF0, bout=1. Then a=0x00, b=0x01: diff=0xFF, bout=1. Then a=b=0xA5: diff=0x00, bout=0.
- Accept a=0x07, b=0x02; pulse start and change a/b to 0xFF while busy: no restart, operands unaffected; result diff=0x05, bout=0; done pulses exactly once.
- start held high continuously with a=0x03, b=0x01: done pulses every 10 cycles, diff=0x02 each time; done never high two consecutive cycles.
- rst_n low for one edge at bit 4 of an operation: next cycle busy=0, done=0, diff=0, bout=0, state IDLE; no done pulse follows; a fresh start then completes normally.
- With SERIAL_SUB_OVF_EN defined: a=0x80, b=0x01 gives diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF gives diff=0x80, ovf=1, bout=1. Then a=0x05, b=0x03 gives ovf=0.
